// File: rtl/zap_tlb_dm_store.sv
// zap_tlb_dm_store: direct-mapped TLB entry store with registered lookup and
// a sequential invalidate sweep that keeps the array RAM-inferable.
module zap_tlb_dm_store #(
    parameter int unsigned ENTRIES = 32'd8,
    parameter int unsigned WDT     = 32'd44,
    parameter int unsigned TAG_WDT = 32'd12,
    parameter int unsigned IDX_LSB = 32'd20
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_wen,
    input  logic [WDT-1:0] i_wdata,
    input  logic [31:0]    i_wadr,
    input  logic           i_rd_en,
    input  logic [31:0]    i_rd_adr,
    input  logic           i_inv,
    output logic [WDT-1:0] o_rdata,
    output logic           o_hit,
    output logic           o_busy
);
    localparam int unsigned IW = $clog2(ENTRIES);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   cnt, cnt_nxt;
    logic [WDT:0]    mem [ENTRIES];
    logic [IW-1:0]   widx, ridx;
    logic            idle, wr, rd;
    logic [WDT:0]    entry;

    assign widx   = i_wadr[IDX_LSB +: IW];
    assign ridx   = i_rd_adr[IDX_LSB +: IW];
    assign idle   = state == IDLE;
    assign wr     = i_wen & idle & ~i_inv;
    assign rd     = i_rd_en & idle & ~i_inv;
    assign o_busy = state == SWEEP;
    assign entry  = (wr && widx == ridx) ? {1'b1, i_wdata} : mem[ridx];

    always_comb begin
        state_nxt = i_inv ? SWEEP : (!idle && cnt == IW'(ENTRIES - 1)) ? IDLE : state;
        cnt_nxt   = i_inv ? '0 : idle ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= SWEEP;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Single write port shared by page-walk fills and the sweep; the sweep
    // zeroes the whole entry, which also clears its valid bit.
    always_ff @(posedge i_clk) begin
        if (!i_reset && (wr || !idle))
            mem[idle ? widx : cnt] <= idle ? {1'b1, i_wdata} : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_hit   <= 1'b0;
            o_rdata <= '0;
        end else if (i_rd_en) begin
            o_hit <= rd & entry[WDT] & (entry[WDT-1 -: TAG_WDT] == i_rd_adr[31 -: TAG_WDT]);
            if (rd)
                o_rdata <= entry[WDT-1:0];
        end
    end
endmodule

// File: tb/tb_zap_tlb_dm_store.sv
// tb_zap_tlb_dm_store: randomized and directed checks of zap_tlb_dm_store
// against an array-level reference model of the TLB.
module tb_zap_tlb_dm_store;
    localparam int ENTRIES = 8;
    localparam int WDT     = 44;

    logic           clk = 0;
    logic           rst;
    logic           wen;
    logic [WDT-1:0] wdata;
    logic [31:0]    wadr;
    logic           rd_en;
    logic [31:0]    rd_adr;
    logic           inv;
    logic [WDT-1:0] rdata;
    logic           hit;
    logic           busy;

    int n_chk = 0;
    int n_bad = 0;

    logic [WDT-1:0] m_data [ENTRIES];
    bit             m_valid [ENTRIES];
    int             busy_left = 0;
    bit             m_hit = 0;
    logic [WDT-1:0] m_rdata = '0;

    zap_tlb_dm_store dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_wen    (wen),
        .i_wdata  (wdata),
        .i_wadr   (wadr),
        .i_rd_en  (rd_en),
        .i_rd_adr (rd_adr),
        .i_inv    (inv),
        .o_rdata  (rdata),
        .o_hit    (hit),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic wipe();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_data[i]  = '0;
        end
        busy_left = ENTRIES;
    endtask

    // One clock: drive, update the model from the sampled inputs, compare.
    task automatic step(input logic r, input logic w, input logic [31:0] wa, input logic [WDT-1:0] wd,
                        input logic re, input logic [31:0] ra, input logic iv);
        int  wi, ri;
        bit  aw, ar, v;
        logic [WDT-1:0] d;
        rst = r; wen = w; wadr = wa; wdata = wd; rd_en = re; rd_adr = ra; inv = iv;
        @(posedge clk);
        wi = int'(wa[22:20]);
        ri = int'(ra[22:20]);
        if (r) begin
            wipe();
            m_hit   = 0;
            m_rdata = '0;
        end else begin
            aw = w && busy_left == 0 && !iv;
            ar = re && busy_left == 0 && !iv;
            if (re) begin
                if (ar) begin
                    v = m_valid[ri];
                    d = m_data[ri];
                    if (aw && wi == ri) begin
                        v = 1;
                        d = wd;
                    end
                    m_hit   = v && d[43:32] == ra[31:20];
                    m_rdata = d;
                end else
                    m_hit = 0;
            end
            if (aw) begin
                m_valid[wi] = 1;
                m_data[wi]  = wd;
            end
            if (iv) wipe();
            else if (busy_left > 0) busy_left--;
        end
        #1;
        chk("busy", 64'(busy), 64'(busy_left > 0));
        chk("hit", 64'(hit), 64'(m_hit));
        chk("rdata", 64'(rdata), 64'(m_rdata));
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            nop();
        end
    endtask

    function automatic logic [31:0] rnd_adr();
        return {9'($urandom_range(0, 1)), 3'($urandom), 20'($urandom)};
    endfunction

    initial begin
        int n;
        bit again;
        logic [31:0] a;
        logic [WDT-1:0] d;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_hit", 64'(hit), 0);
        chk("rst_rdata", 64'(rdata), 0);
        count_busy(n);
        chk("rst_busy_len", 64'(n), 8);
        step(0, 0, 0, 0, 1, 32'h0030_1234, 0);
        chk("empty_hit", 64'(hit), 0);

        // Fill then look up the same index with matching and foreign tags.
        step(0, 1, 32'h0030_0000, {12'h003, 32'hCAFE_0003}, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0030_1234, 0);
        chk("hit_match", 64'(hit), 1);
        chk("rdata_match", 64'(rdata), 64'({12'h003, 32'hCAFE_0003}));
        step(0, 0, 0, 0, 1, 32'h0830_0000, 0);
        chk("hit_tagdiff", 64'(hit), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("hold_rdata", 64'(rdata), 64'({12'h003, 32'hCAFE_0003}));

        step(0, 1, 32'h0050_0000, {12'h005, 32'h1234_5678}, 1, 32'h0050_0000, 0);
        chk("bypass_hit", 64'(hit), 1);
        chk("bypass_rdata", 64'(rdata), 64'({12'h005, 32'h1234_5678}));

        for (int k = 0; k < 400; k++) begin
            int r = $urandom_range(0, 199);
            a = rnd_adr();
            d = {($urandom_range(0, 3) == 0) ? 12'($urandom) : a[31:20], 32'($urandom)};
            step(r == 0, 1'($urandom), a, d, 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0) ? a : rnd_adr(), r >= 1 && r <= 4);
        end
        while (busy_left > 0) nop();

        // Fill everything, then invalidate with a restart inside the sweep.
        for (int i = 0; i < ENTRIES; i++)
            step(0, 1, {9'h0, 3'(i), 20'h0}, {9'h0, 3'(i), 32'($urandom)}, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0060_0000, 0);
        chk("filled_hit", 64'(hit), 1);
        step(0, 0, 0, 0, 0, 0, 1);
        n = 0;
        again = 0;
        while (busy && n < 40) begin
            n++;
            step(0, 1, {9'h0, 3'($urandom), 20'h0}, {9'h0, 3'($urandom), 32'($urandom)}, 0, 0, n == 4 && !again);
            if (n == 4) again = 1;
        end
        chk("sweep_len", 64'(n), 12);
        for (int i = 0; i < ENTRIES; i++) begin
            step(0, 0, 0, 0, 1, {9'h0, 3'(i), 20'h0}, 0);
            chk("post_inv_hit", 64'(hit), 0);
        end

        // Reset landing in the third sweep cycle.
        step(0, 1, 32'h0010_0000, {12'h001, 32'hBEEF_0001}, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0010_0000, 0);
        chk("pre_rst_hit", 64'(hit), 1);
        step(0, 0, 0, 0, 0, 0, 1);
        nop();
        nop();
        step(1, 0, 0, 0, 1, 32'h0010_0000, 0);
        chk("midrst_hit", 64'(hit), 0);
        chk("midrst_rdata", 64'(rdata), 0);
        count_busy(n);
        chk("midrst_busy_len", 64'(n), 8);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
